write_back: RTL and testbench



---
 rtl/write_back.sv | 110 +++++++++++
 tb/tb_write_back.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// write_back: final pipeline stage. Owns the 32-entry integer register file (x0 = 0), two bypassed
// combinational read ports, a one-cycle-late forwarding copy of the last write, and a retire counter (WB_INSTRET_EN).
module write_back #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk_sys_i,
    input  logic            rst_sys_i,
    input  logic [7:0]      ctrl_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] result_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            WB_ena_forwarding_o,
    output logic [4:0]      WB_rd_o,
    output logic [XLEN-1:0] WB_data_forwarding_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret_o
`endif
);

    logic [XLEN-1:0] r_regs [0:NREG-1];
    logic            r_fwd_ena;
    logic [4:0]      r_fwd_rd;
    logic [XLEN-1:0] r_fwd_data;

    logic            w_commit;
    logic            w_we;
    logic            w_rs1_hit;
    logic            w_rs2_hit;

    // Flush squashes the presented instruction regardless of stall.
    assign w_commit = ~stall_i & ~flush_i;
    assign w_we     = w_commit & ctrl_i[7] & (rd_i != 5'd0);

    assign w_rs1_hit = w_we & (rd_i == rs1_addr_i);
    assign w_rs2_hit = w_we & (rd_i == rs2_addr_i);

    always_comb begin
        rs1_data_o = r_regs[rs1_addr_i];
        if (rs1_addr_i == 5'd0) begin
            rs1_data_o = '0;
        end else if (w_rs1_hit) begin
            rs1_data_o = result_i;
        end
    end

    always_comb begin
        rs2_data_o = r_regs[rs2_addr_i];
        if (rs2_addr_i == 5'd0) begin
            rs2_data_o = '0;
        end else if (w_rs2_hit) begin
            rs2_data_o = result_i;
        end
    end

    // Entry 0 is only ever cleared; w_we already excludes rd_i == 0.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[rd_i] <= result_i;
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_fwd_ena  <= 1'b0;
            r_fwd_rd   <= 5'd0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_ena  <= w_we;
            r_fwd_rd   <= w_we ? rd_i : 5'd0;
            r_fwd_data <= w_we ? result_i : '0;
        end
    end

    assign WB_ena_forwarding_o  = r_fwd_ena;
    assign WB_rd_o              = r_fwd_rd;
    assign WB_data_forwarding_o = r_fwd_data;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;
    logic        w_retire;

    // Any non-bubble instruction retires, including stores, branches and x0 writes.
    assign w_retire = w_commit & (ctrl_i != 8'h00);

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_instret <= 64'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret_o = r_instret;
`else
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^ctrl_i[6:0];
`endif

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: reset, bypass, x0 protection, stall/flush, bubbles/stores, counter wrap.
module tb_write_back;

    logic        clk_sys_i = 1'b0;
    logic        rst_sys_i;
    logic [7:0]  ctrl_i;
    logic [4:0]  rd_i;
    logic [63:0] result_i;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [63:0] rs1_data_o;
    logic [63:0] rs2_data_o;
    logic        WB_ena_forwarding_o;
    logic [4:0]  WB_rd_o;
    logic [63:0] WB_data_forwarding_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    write_back #(.XLEN(64), .NREG(32)) dut (
        .clk_sys_i            (clk_sys_i),
        .rst_sys_i            (rst_sys_i),
        .ctrl_i               (ctrl_i),
        .rd_i                 (rd_i),
        .result_i             (result_i),
        .stall_i              (stall_i),
        .flush_i              (flush_i),
        .rs1_addr_i           (rs1_addr_i),
        .rs2_addr_i           (rs2_addr_i),
        .rs1_data_o           (rs1_data_o),
        .rs2_data_o           (rs2_data_o),
        .WB_ena_forwarding_o  (WB_ena_forwarding_o),
        .WB_rd_o              (WB_rd_o),
        .WB_data_forwarding_o (WB_data_forwarding_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o            (instret_o)
`endif
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge, well away from the next one.
    task automatic edge_step();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [63:0] exp);
`ifdef WB_INSTRET_EN
        check(tag, instret_o, exp);
`else
        if (tag.len() == 0) check("cnt_tag", 64'd1, {63'd0, exp[0]});
`endif
    endtask

    initial begin
        rst_sys_i = 1'b1; ctrl_i = 8'h00; rd_i = 5'd0; result_i = 64'd0;
        stall_i = 1'b0; flush_i = 1'b0; rs1_addr_i = 5'd5; rs2_addr_i = 5'd31;
        #1;
        check("rst_rs1", rs1_data_o, 64'd0);
        check("rst_rs2", rs2_data_o, 64'd0);
        check("rst_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd0);
        check("rst_fwd_rd", {59'd0, WB_rd_o}, 64'd0);
        check("rst_fwd_data", WB_data_forwarding_o, 64'd0);
        check_cnt("rst_instret", 64'd0);
        edge_step();
        edge_step();
        rst_sys_i = 1'b0;

        // Write x5 = 0x1234 on the first edge after deassertion.
        ctrl_i = 8'h80; rd_i = 5'd5; result_i = 64'h1234;
        #1;
        check("x5_bypass", rs1_data_o, 64'h1234);
        edge_step();
        ctrl_i = 8'h00;
        check("x5_array", rs1_data_o, 64'h1234);
        check("x5_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd1);
        check("x5_fwd_rd", {59'd0, WB_rd_o}, 64'd5);
        check_cnt("x5_instret", 64'd1);

        // Asynchronous reset mid-run, then a write presented while in reset.
        rst_sys_i = 1'b1;
        #1;
        check("arst_x5", rs1_data_o, 64'd0);
        check("arst_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd0);
        check_cnt("arst_instret", 64'd0);
        ctrl_i = 8'h80; rd_i = 5'd6; result_i = 64'd77; rs2_addr_i = 5'd6;
        edge_step();
        ctrl_i = 8'h00;
        rst_sys_i = 1'b0;
        #1;
        check("rst_write_lost", rs2_data_o, 64'd0);

        // Write-through on x7 from both ports.
        ctrl_i = 8'h80; rd_i = 5'd7; result_i = 64'hDEADBEEF; rs1_addr_i = 5'd7; rs2_addr_i = 5'd7;
        #1;
        check("wt_rs1", rs1_data_o, 64'hDEADBEEF);
        check("wt_rs2", rs2_data_o, 64'hDEADBEEF);
        edge_step();
        ctrl_i = 8'h00;
        check("wt_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd1);
        check("wt_fwd_rd", {59'd0, WB_rd_o}, 64'd7);
        check("wt_fwd_data", WB_data_forwarding_o, 64'hDEADBEEF);
        check_cnt("wt_instret", 64'd1);
        edge_step();
        check("wt_fwd_drop", {63'd0, WB_ena_forwarding_o}, 64'd0);
        check("wt_fwd_rd_clr", {59'd0, WB_rd_o}, 64'd0);
        check("wt_fwd_data_clr", WB_data_forwarding_o, 64'd0);

        // x0 write attempt: ignored but still retires.
        ctrl_i = 8'h80; rd_i = 5'd0; result_i = 64'hFFFF; rs1_addr_i = 5'd0;
        #1;
        check("x0_bypass", rs1_data_o, 64'd0);
        edge_step();
        ctrl_i = 8'h00;
        check("x0_read", rs1_data_o, 64'd0);
        check("x0_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd0);
        check_cnt("x0_instret", 64'd2);

        // x31 boundary write.
        ctrl_i = 8'h80; rd_i = 5'd31; result_i = 64'h8000_0000_0000_0001; rs2_addr_i = 5'd31;
        edge_step();
        ctrl_i = 8'h00;
        check("x31_array", rs2_data_o, 64'h8000_0000_0000_0001);
        check("x31_fwd_rd", {59'd0, WB_rd_o}, 64'd31);
        check_cnt("x31_instret", 64'd3);

        // Stall for two edges, then release.
        ctrl_i = 8'h80; rd_i = 5'd3; result_i = 64'd5; stall_i = 1'b1; rs2_addr_i = 5'd3;
        #1;
        check("stall_no_bypass", rs2_data_o, 64'd0);
        edge_step();
        check("stall1_x3", rs2_data_o, 64'd0);
        check("stall1_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd0);
        edge_step();
        check("stall2_x3", rs2_data_o, 64'd0);
        check_cnt("stall2_instret", 64'd3);
        stall_i = 1'b0;
        #1;
        check("release_bypass", rs2_data_o, 64'd5);
        edge_step();
        ctrl_i = 8'h00;
        check("release_x3", rs2_data_o, 64'd5);
        check("release_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd1);
        check("release_fwd_rd", {59'd0, WB_rd_o}, 64'd3);
        check_cnt("release_instret", 64'd4);

        // Flush with stall, then flush alone: neither writes nor counts.
        ctrl_i = 8'h80; rd_i = 5'd4; result_i = 64'd9; flush_i = 1'b1; stall_i = 1'b1; rs1_addr_i = 5'd4;
        #1;
        check("flush_no_bypass", rs1_data_o, 64'd0);
        edge_step();
        stall_i = 1'b0; rd_i = 5'd3; result_i = 64'd99;
        check("flushst_x4", rs1_data_o, 64'd0);
        check("flushst_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd0);
        edge_step();
        ctrl_i = 8'h00; flush_i = 1'b0;
        check("flush_x3_kept", rs2_data_o, 64'd5);
        check("flush_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd0);
        check_cnt("flush_instret", 64'd4);

        // Alternate bubbles and stores for 10 cycles: five retire, nothing written.
        rd_i = 5'd3; result_i = 64'hAAAA; rs1_addr_i = 5'd7;
        for (int i = 0; i < 10; i++) begin
            ctrl_i = (i % 2 == 0) ? 8'h00 : 8'h28;
            edge_step();
        end
        ctrl_i = 8'h00;
        check("store_x3", rs2_data_o, 64'd5);
        check("store_x7", rs1_data_o, 64'hDEADBEEF);
        check("store_fwd_ena", {63'd0, WB_ena_forwarding_o}, 64'd0);
        check_cnt("store_instret", 64'd9);

`ifdef WB_INSTRET_EN
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        check("wrap_preload", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        ctrl_i = 8'h80; rd_i = 5'd8; result_i = 64'd1; rs1_addr_i = 5'd8;
        edge_step();
        ctrl_i = 8'h00;
        check("wrap_x8", rs1_data_o, 64'd1);
        check_cnt("wrap_instret", 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
